// File: rtl/hdb3_rx.sv
// HDB3 line receiver: strips 000V/B00V substitutions through a 4-symbol delay line
// and flags code, violation and zero-run errors with a saturating error count.
module hdb3_rx #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sym_valid,
  input  logic [1:0]       i_hdb3_code,
  input  logic             i_cnt_clr,
  output logic             o_data,
  output logic             o_data_valid,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_locked
);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCK} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       pipe_q, pipe_d;
  logic [2:0]       r_q, r_d;
  logic             pol_q, lastv_q;
  logic [2:0]       fill_q;
  logic             data_q, data_vld_q, err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_mark, sym_neg, illegal, pol_def, is_v;
  logic code_err, viol_err, zero_err, sym_err;

  // Symbol classification and error detection; pol is defined once we leave IDLE
  always_comb begin
    is_mark  = (i_hdb3_code == 2'b01) || (i_hdb3_code == 2'b10);
    sym_neg  = (i_hdb3_code == 2'b10);
    illegal  = (i_hdb3_code == 2'b11);
    pol_def  = (state_q != S_IDLE);
    is_v     = is_mark && pol_def && (sym_neg == pol_q);
    code_err = illegal;
    viol_err = is_v && (r_q[0] || r_q[1] || ((state_q == S_LOCK) && (sym_neg == lastv_q)));
    zero_err = !is_mark && (r_q == 3'b000);
    sym_err  = i_sym_valid && (code_err || viol_err || zero_err);
  end

  always_comb begin
    pipe_d = is_v ? 4'b0000 : {pipe_q[2:0], is_mark};
    r_d    = illegal ? r_q : {r_q[1:0], is_mark};
    cnt_d  = cnt_q;
    if (i_cnt_clr)    cnt_d = '0;
    else if (sym_err) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_q     <= '0;
      r_q        <= '0;
      pol_q      <= 1'b0;
      lastv_q    <= 1'b0;
      fill_q     <= '0;
      data_q     <= 1'b0;
      data_vld_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      data_vld_q <= 1'b0;
      err_q      <= sym_err;
      cnt_q      <= cnt_d;
      if (i_sym_valid) begin
        data_q     <= pipe_q[3];
        data_vld_q <= (fill_q == 3'd4);
        pipe_q     <= pipe_d;
        r_q        <= r_d;
        if (is_mark) pol_q   <= sym_neg;
        if (is_v)    lastv_q <= sym_neg;
        if (fill_q != 3'd4) fill_q <= fill_q + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_sym_valid) begin
      unique case (state_q)
        S_IDLE:  if (is_mark)              state_d = S_TRACK;
        S_TRACK: if (is_v && !sym_err)     state_d = S_LOCK;
        S_LOCK:  if (sym_err)              state_d = S_TRACK;
        default:                           state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_locked     = (state_q == S_LOCK);
    o_data       = data_q;
    o_data_valid = data_vld_q;
    o_err        = err_q;
    o_err_cnt    = cnt_q;
  end

endmodule

// File: tb/tb_hdb3_rx.sv
// Directed bench for hdb3_rx: decode, lock, error detection, counter saturation and reset.
module tb_hdb3_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vld = 1'b0;
  logic [1:0]  code = 2'b00;
  logic        clr = 1'b0;

  logic        data, dv, err, lock;
  logic [15:0] cnt;
  logic        data4, dv4, err4, lock4;
  logic [3:0]  cnt4;

  logic        s_data, s_dv, s_err, s_lock;
  logic [15:0] s_cnt;
  logic [3:0]  s_cnt4;

  int checks = 0;
  int failures = 0;

  logic [1:0] seq1 [0:9] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
  logic       exp1 [0:5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  hdb3_rx #(.CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_sym_valid(vld), .i_hdb3_code(code), .i_cnt_clr(clr),
    .o_data(data), .o_data_valid(dv), .o_err(err), .o_err_cnt(cnt), .o_locked(lock)
  );

  hdb3_rx #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_sym_valid(vld), .i_hdb3_code(code), .i_cnt_clr(clr),
    .o_data(data4), .o_data_valid(dv4), .o_err(err4), .o_err_cnt(cnt4), .o_locked(lock4)
  );

  always #5 clk = ~clk;

  task automatic sample();
    s_data = data; s_dv = dv; s_err = err; s_lock = lock; s_cnt = cnt; s_cnt4 = cnt4;
  endtask

  task automatic strobe(input logic [1:0] c);
    @(negedge clk);
    vld = 1'b1; code = c;
    @(posedge clk); #1;
    sample();
    vld = 1'b0; code = 2'b00;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; vld = 1'b1; code = 2'b01;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      sample();
      checks++;
      if ({s_data, s_dv, s_err, s_lock} !== 4'b0000 || s_cnt !== 16'd0 || s_cnt4 !== 4'd0) begin
        failures++;
        $display("FAIL reset_outputs: data/dv/err/lock=%b%b%b%b cnt=%0d cnt4=%0d, required all 0",
                 s_data, s_dv, s_err, s_lock, s_cnt, s_cnt4);
      end
    end
    @(negedge clk);
    rst = 1'b0; vld = 1'b0; code = 2'b00;
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk); #1;
    sample();
    checks++;
    if (s_lock !== 1'b0 || s_dv !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: lock=%b dv=%b, required 0 0", s_lock, s_dv);
    end
  endtask

  // Scenario 1 with idle gaps of 0..2 cycles between strobes
  task automatic test_basic_decode();
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      strobe(seq1[i-1]);
      checks++;
      if (s_dv !== (i >= 5)) begin
        failures++;
        $display("FAIL basic_dv strobe %0d: got %b, required %b", i, s_dv, (i >= 5));
      end
      if (i >= 5) begin
        checks++;
        if (s_data !== exp1[i-5]) begin
          failures++;
          $display("FAIL basic_data strobe %0d: got %b, required %b", i, s_data, exp1[i-5]);
        end
      end
      checks++;
      if (s_err !== 1'b0 || s_lock !== (i >= 5)) begin
        failures++;
        $display("FAIL basic_err_lock strobe %0d: err=%b lock=%b, required 0 %b", i, s_err, s_lock, (i >= 5));
      end
      repeat (i % 3) @(posedge clk);
    end
    #1;
    checks++;
    if (dv !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_gap: dv=%b err=%b while idle, required 0 0", dv, err);
    end
  endtask

  // Back-to-back all-zero data carried as B00V groups after locking on 000V
  task automatic test_back_to_back();
    logic [1:0] s2 [0:20] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01,
                              2'b10, 2'b00, 2'b00, 2'b10,
                              2'b01, 2'b00, 2'b00, 2'b01,
                              2'b10, 2'b00, 2'b00, 2'b10,
                              2'b01, 2'b00, 2'b00, 2'b01};
    apply_reset();
    for (int i = 1; i <= 21; i++) begin
      strobe(s2[i-1]);
      if (i >= 5) begin
        checks++;
        if (s_dv !== 1'b1 || s_data !== (i == 5) || s_lock !== 1'b1) begin
          failures++;
          $display("FAIL zeros_data strobe %0d: dv=%b data=%b lock=%b, required 1 %b 1",
                   i, s_dv, s_data, s_lock, (i == 5));
        end
      end
      checks++;
      if (s_err !== 1'b0) begin
        failures++;
        $display("FAIL zeros_err strobe %0d: got %b, required 0", i, s_err);
      end
    end
    checks++;
    if (s_cnt !== 16'd0) begin
      failures++;
      $display("FAIL zeros_cnt: got %0d, required 0", s_cnt);
    end
  endtask

  // Continues from the locked state left by test_back_to_back
  task automatic test_illegal_code();
    logic [1:0] s3 [0:7] = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
    for (int i = 1; i <= 8; i++) begin
      strobe(s3[i-1]);
      checks++;
      if (s_err !== (i == 2)) begin
        failures++;
        $display("FAIL illegal_err strobe %0d: got %b, required %b", i, s_err, (i == 2));
      end
      if (i == 2) begin
        checks++;
        if (s_cnt !== 16'd1 || s_lock !== 1'b0) begin
          failures++;
          $display("FAIL illegal_cnt_lock: cnt=%0d lock=%b, required 1 0", s_cnt, s_lock);
        end
      end
      if (i == 6 || i == 8) begin
        checks++;
        if (s_dv !== 1'b1 || s_data !== (i == 8)) begin
          failures++;
          $display("FAIL illegal_data strobe %0d: dv=%b data=%b, required 1 %b", i, s_dv, s_data, (i == 8));
        end
      end
    end
  endtask

  task automatic test_zero_run();
    logic [1:0] s4 [0:9] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      strobe(s4[i-1]);
      if (i >= 6) begin
        checks++;
        if (s_err !== (i >= 9)) begin
          failures++;
          $display("FAIL zero_run_err zero %0d: got %b, required %b", i - 5, s_err, (i >= 9));
        end
      end
      if (i == 8 || i == 9) begin
        checks++;
        if (s_lock !== (i == 8)) begin
          failures++;
          $display("FAIL zero_run_lock zero %0d: got %b, required %b", i - 5, s_lock, (i == 8));
        end
      end
    end
    checks++;
    if (s_cnt !== 16'd2) begin
      failures++;
      $display("FAIL zero_run_cnt: got %0d, required 2", s_cnt);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      strobe(2'b11);
      if (i == 15 || i == 16 || i == 20) begin
        checks++;
        if (s_cnt4 !== 4'd15 || s_cnt !== 16'(i) || s_err !== 1'b1) begin
          failures++;
          $display("FAIL sat_cnt strobe %0d: cnt4=%0d cnt=%0d err=%b, required 15 %0d 1",
                   i, s_cnt4, s_cnt, s_err, i);
        end
      end
    end
    clr = 1'b1;
    strobe(2'b11);
    clr = 1'b0;
    checks++;
    if (s_cnt4 !== 4'd0 || s_cnt !== 16'd0 || s_err !== 1'b1) begin
      failures++;
      $display("FAIL clr_priority: cnt4=%0d cnt=%0d err=%b, required 0 0 1", s_cnt4, s_cnt, s_err);
    end
    strobe(2'b11);
    checks++;
    if (s_cnt4 !== 4'd1 || s_cnt !== 16'd1) begin
      failures++;
      $display("FAIL count_after_clr: cnt4=%0d cnt=%0d, required 1 1", s_cnt4, s_cnt);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 0; i < 7; i++) strobe(seq1[i]);
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      strobe(seq1[i-1]);
      checks++;
      if (s_dv !== (i >= 5)) begin
        failures++;
        $display("FAIL mid_reset_dv strobe %0d: got %b, required %b", i, s_dv, (i >= 5));
      end
      if (i >= 5) begin
        checks++;
        if (s_data !== exp1[i-5]) begin
          failures++;
          $display("FAIL mid_reset_data strobe %0d: got %b, required %b", i, s_data, exp1[i-5]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_decode();
    test_back_to_back();
    test_illegal_code();
    test_zero_run();
    test_saturation();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
